pad_gpio_ctrl: RTL and testbench

PAD_GPIO_CTRL -- requirements
Module: pad_gpio_ctrl

---
 rtl/pad_gpio_pkg.sv | 26 ++
 rtl/pad_gpio_filter.sv | 71 +++++++
 rtl/pad_gpio_ctrl.sv | 135 +++++++++++++
 tb/tb_pad_gpio_ctrl.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/pad_gpio_pkg.sv
// Shared types and defaults for the GPIO pad controller.
// Pad-enable helper keeps the push-pull / open-drain encoding in one place.
package pad_gpio_pkg;

    localparam int PAD_SYNC_STAGES_DEF = 2;
    localparam int PAD_FILT_W_DEF      = 4;

    typedef enum logic {
        PAD_PUSH_PULL  = 1'b0,
        PAD_OPEN_DRAIN = 1'b1
    } pad_mode_e;

    typedef enum logic {
        EVT_IDLE = 1'b0,
        EVT_PEND = 1'b1
    } evt_state_e;

    // OEN is active-low; open-drain only ever drives low, so a '1' releases the pin.
    function automatic logic pad_oen_f(input pad_mode_e mode, input logic oe, input logic dout);
        if (mode == PAD_OPEN_DRAIN)
            return ~oe | dout;
        else
            return ~oe;
    endfunction

endpackage

// File: rtl/pad_gpio_filter.sv
// Glitch filter on the synchronized pin level; with PAD_GPIO_CTRL_FILTER_EN undefined it is a
// single register stage and the threshold is ignored. Edge pulses coincide with the in_o toggle.
module pad_gpio_filter
    import pad_gpio_pkg::*;
#(
    parameter int FILT_W = PAD_FILT_W_DEF
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              s_i,
    input  logic [FILT_W-1:0] thr_i,
    output logic              in_o,
    output logic              rise_o,
    output logic              fall_o
);

    logic r_in;
    logic r_rise;
    logic r_fall;

`ifdef PAD_GPIO_CTRL_FILTER_EN
    logic [FILT_W-1:0] r_cnt;
    logic              w_mis;
    logic              w_fire;

    assign w_mis  = (s_i != r_in);
    assign w_fire = w_mis && (r_cnt >= thr_i);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_in   <= 1'b0;
            r_cnt  <= '0;
            r_rise <= 1'b0;
            r_fall <= 1'b0;
        end else begin
            r_rise <= w_fire & s_i;
            r_fall <= w_fire & ~s_i;
            if (w_fire) begin
                r_in  <= s_i;
                r_cnt <= '0;
            end else if (w_mis) begin
                // Saturate so a threshold raised mid-count cannot wrap back to zero.
                if (r_cnt != '1)
                    r_cnt <= r_cnt + 1'b1;
            end else begin
                r_cnt <= '0;
            end
        end
    end
`else
    logic w_unused_thr;
    assign w_unused_thr = ^thr_i;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_in   <= 1'b0;
            r_rise <= 1'b0;
            r_fall <= 1'b0;
        end else begin
            r_in   <= s_i;
            r_rise <= s_i & ~r_in;
            r_fall <= ~s_i & r_in;
        end
    end
`endif

    assign in_o   = r_in;
    assign rise_o = r_rise;
    assign fall_o = r_fall;

endmodule

// File: rtl/pad_gpio_ctrl.sv
// GPIO pad controller: registered pad drive, synchronized/filtered input, one-slot edge event.
// Optional glitch filter via PAD_GPIO_CTRL_FILTER_EN; events are dropped (sticky ovf) when the slot is full.
module pad_gpio_ctrl
    import pad_gpio_pkg::*;
#(
    parameter int SYNC_STAGES = PAD_SYNC_STAGES_DEF,
    parameter int FILT_W      = PAD_FILT_W_DEF
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              cfg_oe_i,
    input  logic              cfg_od_i,
    input  logic              cfg_pull_en_i,
    input  logic              out_i,
    input  logic [FILT_W-1:0] filt_thr_i,
    output logic              pad_oen_o,
    output logic              pad_i_o,
    output logic              pad_pen_o,
    input  logic              pad_o_i,
    output logic              in_o,
    output logic              rise_o,
    output logic              fall_o,
    output logic              evt_valid_o,
    output logic              evt_edge_o,
    input  logic              evt_ready_i,
    output logic              evt_ovf_o,
    input  logic              ovf_clr_i
);

    generate
        if (SYNC_STAGES < 2) begin : g_bad_sync
            $error("pad_gpio_ctrl: SYNC_STAGES must be at least 2");
        end
    endgenerate

    pad_mode_e  w_mode;
    logic       r_pad_oen;
    logic       r_pad_i;
    logic       r_pad_pen;

    assign w_mode = cfg_od_i ? PAD_OPEN_DRAIN : PAD_PUSH_PULL;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_pad_oen <= 1'b1;
            r_pad_i   <= 1'b0;
            r_pad_pen <= 1'b0;
        end else begin
            r_pad_oen <= pad_oen_f(w_mode, cfg_oe_i, out_i);
            r_pad_i   <= (w_mode == PAD_OPEN_DRAIN) ? 1'b0 : out_i;
            r_pad_pen <= ~cfg_pull_en_i;
        end
    end

    assign pad_oen_o = r_pad_oen;
    assign pad_i_o   = r_pad_i;
    assign pad_pen_o = r_pad_pen;

    // Input path runs regardless of drive state so the pin can be read back.
    logic [SYNC_STAGES-1:0] r_sync;
    logic                   w_s;

    always_ff @(posedge clk_i) begin
        if (rst_i)
            r_sync <= '0;
        else
            r_sync <= {r_sync[SYNC_STAGES-2:0], pad_o_i};
    end

    assign w_s = r_sync[SYNC_STAGES-1];

    logic w_rise;
    logic w_fall;
    logic w_edge;

    pad_gpio_filter #(
        .FILT_W (FILT_W)
    ) u_filter (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .s_i    (w_s),
        .thr_i  (filt_thr_i),
        .in_o   (in_o),
        .rise_o (w_rise),
        .fall_o (w_fall)
    );

    assign rise_o = w_rise;
    assign fall_o = w_fall;
    assign w_edge = w_rise | w_fall;

    evt_state_e r_state;
    logic       r_evt_valid;
    logic       r_evt_edge;
    logic       r_evt_ovf;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state     <= EVT_IDLE;
            r_evt_valid <= 1'b0;
            r_evt_edge  <= 1'b0;
            r_evt_ovf   <= 1'b0;
        end else begin
            case (r_state)
                EVT_IDLE: begin
                    if (w_edge) begin
                        r_state     <= EVT_PEND;
                        r_evt_valid <= 1'b1;
                        r_evt_edge  <= w_rise;
                    end
                end
                EVT_PEND: begin
                    if (evt_ready_i) begin
                        if (w_edge) begin
                            r_evt_edge <= w_rise;
                        end else begin
                            r_state     <= EVT_IDLE;
                            r_evt_valid <= 1'b0;
                        end
                    end
                end
            endcase
            // A dropped edge outranks a software clear in the same cycle.
            if ((r_state == EVT_PEND) && w_edge && !evt_ready_i)
                r_evt_ovf <= 1'b1;
            else if (ovf_clr_i)
                r_evt_ovf <= 1'b0;
        end
    end

    assign evt_valid_o = r_evt_valid;
    assign evt_edge_o  = r_evt_edge;
    assign evt_ovf_o   = r_evt_ovf;

endmodule

// File: tb/tb_pad_gpio_ctrl.sv
// Directed bench for pad_gpio_ctrl (SYNC_STAGES=2, FILT_W=4); filter-specific steps follow
// whichever build of PAD_GPIO_CTRL_FILTER_EN is compiled.
module tb_pad_gpio_ctrl;

    logic       clk_i = 1'b0;
    logic       rst_i;
    logic       cfg_oe_i;
    logic       cfg_od_i;
    logic       cfg_pull_en_i;
    logic       out_i;
    logic [3:0] filt_thr_i;
    logic       pad_oen_o;
    logic       pad_i_o;
    logic       pad_pen_o;
    logic       pad_o_i;
    logic       in_o;
    logic       rise_o;
    logic       fall_o;
    logic       evt_valid_o;
    logic       evt_edge_o;
    logic       evt_ready_i;
    logic       evt_ovf_o;
    logic       ovf_clr_i;

    int n_pass = 0;
    int n_tot  = 0;

    always #5 clk_i = ~clk_i;

    pad_gpio_ctrl dut (
        .clk_i         (clk_i),
        .rst_i         (rst_i),
        .cfg_oe_i      (cfg_oe_i),
        .cfg_od_i      (cfg_od_i),
        .cfg_pull_en_i (cfg_pull_en_i),
        .out_i         (out_i),
        .filt_thr_i    (filt_thr_i),
        .pad_oen_o     (pad_oen_o),
        .pad_i_o       (pad_i_o),
        .pad_pen_o     (pad_pen_o),
        .pad_o_i       (pad_o_i),
        .in_o          (in_o),
        .rise_o        (rise_o),
        .fall_o        (fall_o),
        .evt_valid_o   (evt_valid_o),
        .evt_edge_o    (evt_edge_o),
        .evt_ready_i   (evt_ready_i),
        .evt_ovf_o     (evt_ovf_o),
        .ovf_clr_i     (ovf_clr_i)
    );

    task automatic step(input int n);
        repeat (n) @(posedge clk_i);
        #1;
    endtask

    task automatic chk(input string tag, input logic obs, input logic exp);
        n_tot++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    endtask

    initial begin
        rst_i         = 1'b1;
        cfg_oe_i      = 1'b0;
        cfg_od_i      = 1'b0;
        cfg_pull_en_i = 1'b1;
        out_i         = 1'b0;
        filt_thr_i    = 4'd0;
        pad_o_i       = 1'b0;
        evt_ready_i   = 1'b0;
        ovf_clr_i     = 1'b0;

        // Reset values
        step(2);
        chk("rst_oen", pad_oen_o, 1'b1);
        chk("rst_pad_i", pad_i_o, 1'b0);
        chk("rst_pen", pad_pen_o, 1'b0);
        chk("rst_in", in_o, 1'b0);
        chk("rst_valid", evt_valid_o, 1'b0);
        chk("rst_ovf", evt_ovf_o, 1'b0);
        rst_i = 1'b0;
        step(1);
        chk("idle_oen", pad_oen_o, 1'b1);
        chk("idle_pen", pad_pen_o, 1'b0);
        chk("idle_in", in_o, 1'b0);
        chk("idle_valid", evt_valid_o, 1'b0);

        // Pull enable
        cfg_pull_en_i = 1'b0;
        step(1);
        chk("pull_off_pen", pad_pen_o, 1'b1);
        cfg_pull_en_i = 1'b1;
        step(1);
        chk("pull_on_pen", pad_pen_o, 1'b0);

        // Push-pull, including one-cycle latency
        cfg_oe_i = 1'b1;
        out_i    = 1'b1;
        #1;
        chk("pp_before_edge_i", pad_i_o, 1'b0);
        step(1);
        chk("pp_oen", pad_oen_o, 1'b0);
        chk("pp_i_hi", pad_i_o, 1'b1);
        out_i = 1'b0;
        step(1);
        chk("pp_i_lo", pad_i_o, 1'b0);

        // Open-drain 1 -> 0 -> 1
        cfg_od_i = 1'b1;
        out_i    = 1'b1;
        step(1);
        chk("od_rel_oen", pad_oen_o, 1'b1);
        chk("od_rel_i", pad_i_o, 1'b0);
        out_i = 1'b0;
        step(1);
        chk("od_low_oen", pad_oen_o, 1'b0);
        chk("od_low_i", pad_i_o, 1'b0);
        out_i = 1'b1;
        step(1);
        chk("od_rel2_oen", pad_oen_o, 1'b1);
        chk("od_rel2_i", pad_i_o, 1'b0);
        cfg_oe_i = 1'b0;
        out_i    = 1'b0;
        step(1);
        chk("od_oe0_oen", pad_oen_o, 1'b1);

        // One-cycle pin pulse, T=0: in_o pulses 3 cycles later; second edge overflows
        pad_o_i = 1'b1;
        step(1);
        chk("pulse_in_e1", in_o, 1'b0);
        pad_o_i = 1'b0;
        step(1);
        chk("pulse_in_e2", in_o, 1'b0);
        step(1);
        chk("pulse_in_e3", in_o, 1'b1);
        chk("pulse_rise_e3", rise_o, 1'b1);
        chk("pulse_fall_e3", fall_o, 1'b0);
        step(1);
        chk("pulse_in_e4", in_o, 1'b0);
        chk("pulse_rise_e4", rise_o, 1'b0);
        chk("pulse_fall_e4", fall_o, 1'b1);
        chk("evt_valid_e4", evt_valid_o, 1'b1);
        chk("evt_edge_e4", evt_edge_o, 1'b1);
        chk("evt_ovf_e4", evt_ovf_o, 1'b0);
        step(1);
        chk("pulse_fall_e5", fall_o, 1'b0);
        chk("ovf_valid", evt_valid_o, 1'b1);
        chk("ovf_edge_kept", evt_edge_o, 1'b1);
        chk("ovf_set", evt_ovf_o, 1'b1);
        ovf_clr_i = 1'b1;
        step(1);
        ovf_clr_i = 1'b0;
        chk("ovf_clr", evt_ovf_o, 1'b0);
        chk("ovf_clr_valid", evt_valid_o, 1'b1);

        // Handshake drains the slot
        evt_ready_i = 1'b1;
        step(1);
        evt_ready_i = 1'b0;
        chk("hs_idle", evt_valid_o, 1'b0);

        // Rise loads the slot, then a fall coincident with valid&ready replaces it
        pad_o_i = 1'b1;
        step(3);
        chk("rise_in", in_o, 1'b1);
        chk("rise_pulse", rise_o, 1'b1);
        step(1);
        chk("rise_once", rise_o, 1'b0);
        chk("rise_valid", evt_valid_o, 1'b1);
        chk("rise_edge", evt_edge_o, 1'b1);
        pad_o_i = 1'b0;
        step(3);
        chk("fall_pulse", fall_o, 1'b1);
        chk("fall_edge_stable", evt_edge_o, 1'b1);
        evt_ready_i = 1'b1;
        step(1);
        evt_ready_i = 1'b0;
        chk("coinc_valid", evt_valid_o, 1'b1);
        chk("coinc_edge", evt_edge_o, 1'b0);
        chk("coinc_ovf", evt_ovf_o, 1'b0);
        step(1);
        chk("coinc_hold_edge", evt_edge_o, 1'b0);
        evt_ready_i = 1'b1;
        step(1);
        evt_ready_i = 1'b0;
        chk("coinc_drain", evt_valid_o, 1'b0);

`ifdef PAD_GPIO_CTRL_FILTER_EN
        // T=3: 3-cycle pulse rejected, 10-cycle level accepted after 6 cycles
        filt_thr_i = 4'd3;
        pad_o_i    = 1'b1;
        step(3);
        pad_o_i = 1'b0;
        step(3);
        chk("glitch_in_a", in_o, 1'b0);
        step(3);
        chk("glitch_in_b", in_o, 1'b0);
        pad_o_i = 1'b1;
        step(5);
        chk("long_in_c5", in_o, 1'b0);
        step(1);
        chk("long_in_c6", in_o, 1'b1);
        chk("long_rise_c6", rise_o, 1'b1);
        step(1);
        chk("long_rise_c7", rise_o, 1'b0);
        step(3);

        // Lower T mid-count: toggles on the next mismatch cycle
        filt_thr_i = 4'd8;
        pad_o_i    = 1'b0;
        step(5);
        chk("lower_before", in_o, 1'b1);
        filt_thr_i = 4'd2;
        step(1);
        chk("lower_in", in_o, 1'b0);
        chk("lower_fall", fall_o, 1'b1);
        filt_thr_i = 4'd0;
        step(2);
`else
        // Threshold has no effect without the filter
        filt_thr_i = 4'd15;
        pad_o_i    = 1'b1;
        step(1);
        pad_o_i = 1'b0;
        step(2);
        chk("nofilt_in_hi", in_o, 1'b1);
        chk("nofilt_rise", rise_o, 1'b1);
        step(1);
        chk("nofilt_in_lo", in_o, 1'b0);
        filt_thr_i = 4'd0;
        step(2);
`endif

        // Reset while pending and driving discards everything in one edge
        pad_o_i  = 1'b1;
        cfg_oe_i = 1'b1;
        cfg_od_i = 1'b0;
        out_i    = 1'b1;
        step(4);
        chk("pre_rst_in", in_o, 1'b1);
        chk("pre_rst_valid", evt_valid_o, 1'b1);
        chk("pre_rst_oen", pad_oen_o, 1'b0);
        chk("pre_rst_i", pad_i_o, 1'b1);
        rst_i = 1'b1;
        step(1);
        chk("mid_rst_in", in_o, 1'b0);
        chk("mid_rst_valid", evt_valid_o, 1'b0);
        chk("mid_rst_edge", evt_edge_o, 1'b0);
        chk("mid_rst_ovf", evt_ovf_o, 1'b0);
        chk("mid_rst_oen", pad_oen_o, 1'b1);
        chk("mid_rst_i", pad_i_o, 1'b0);
        chk("mid_rst_pen", pad_pen_o, 1'b0);
        rst_i = 1'b0;
        step(1);

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule
